// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the iterative divider
package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = 5;

   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

   // Magnitude of a two's-complement operand when signed mode is selected.
   // 0x80000000 maps onto itself, which is the correct 32-bit magnitude.
   function automatic logic [DIV_WIDTH-1:0] div_abs(
      input logic [DIV_WIDTH-1:0] value,
      input logic                 is_signed
   );
      return (is_signed && value[DIV_WIDTH-1]) ? -value : value;
   endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-subtract step producing one quotient bit
module div_step
   import div_pkg::*;
(
   input  logic [DIV_WIDTH-1:0] rem_in,
   input  logic [DIV_WIDTH-1:0] divisor,
   input  logic                 dividend_bit,
   output logic [DIV_WIDTH-1:0] rem_out,
   output logic                 quot_bit
);

   // rem_in < divisor always holds, so the shifted value fits in 33 bits
   // and the 33-bit difference carries a reliable sign in its top bit.
   logic [DIV_WIDTH:0] shifted;
   logic [DIV_WIDTH:0] diff;

   assign shifted  = {rem_in, dividend_bit};
   assign diff     = shifted - {1'b0, divisor};
   assign quot_bit = ~diff[DIV_WIDTH];
   assign rem_out  = quot_bit ? diff[DIV_WIDTH-1:0] : shifted[DIV_WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-bit signed/unsigned iterative divider; DIV_ZERO_FLAG_EN adds div_by_zero
module div_unit
   import div_pkg::*;
(
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 div_start,
   input  logic                 div_signed,
   input  logic [DIV_WIDTH-1:0] div_src1,
   input  logic [DIV_WIDTH-1:0] div_src2,
   input  logic                 div_cancel,
   output logic                 div_busy,
   output logic                 div_ready,
`ifdef DIV_ZERO_FLAG_EN
   output logic                 div_by_zero,
`endif
   output logic [DIV_WIDTH-1:0] div_quotient,
   output logic [DIV_WIDTH-1:0] div_remainder
);

   localparam logic [DIV_CNT_W-1:0] CNT_LAST = '1;

   div_state_e state;
   div_state_e next_state;

   logic [DIV_CNT_W-1:0] cnt;
   logic [DIV_WIDTH-1:0] part_rem;
   logic [DIV_WIDTH-1:0] dividend_sh;
   logic [DIV_WIDTH-1:0] divisor_r;
   logic [DIV_WIDTH-2:0] quot_acc;
   logic                 neg_quot;
   logic                 neg_rem;

   logic                 accept;
   logic                 zero_div;
   logic [DIV_WIDTH-1:0] step_rem;
   logic                 step_q;
   logic [DIV_WIDTH-1:0] quot_final;

   assign accept     = ((state == IDLE) || (state == DONE)) && div_start && !div_cancel;
   assign zero_div   = (div_src2 == '0);
   assign quot_final = {quot_acc, step_q};

   div_step u_step (
      .rem_in       (part_rem),
      .divisor      (divisor_r),
      .dividend_bit (dividend_sh[DIV_WIDTH-1]),
      .rem_out      (step_rem),
      .quot_bit     (step_q)
   );

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state selection and status outputs; cancel outranks any start.
   always_comb begin
      next_state = state;
      div_busy   = 1'b0;
      div_ready  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               next_state = zero_div ? DONE : RUN;
            end
         end
         RUN: begin
            div_busy = 1'b1;
            if (div_cancel) begin
               next_state = IDLE;
            end else if (cnt == CNT_LAST) begin
               next_state = DONE;
            end
         end
         DONE: begin
            div_busy  = 1'b1;
            div_ready = 1'b1;
            if (div_cancel) begin
               next_state = IDLE;
            end else if (accept) begin
               next_state = zero_div ? DONE : RUN;
            end else begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Operand capture, per-cycle iteration and result registration on entry to DONE.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt           <= '0;
         part_rem      <= '0;
         dividend_sh   <= '0;
         divisor_r     <= '0;
         quot_acc      <= '0;
         neg_quot      <= 1'b0;
         neg_rem       <= 1'b0;
         div_quotient  <= '0;
         div_remainder <= '0;
      end else if (accept) begin
         cnt         <= '0;
         part_rem    <= '0;
         dividend_sh <= div_abs(div_src1, div_signed);
         divisor_r   <= div_abs(div_src2, div_signed);
         quot_acc    <= '0;
         neg_quot    <= div_signed & (div_src1[DIV_WIDTH-1] ^ div_src2[DIV_WIDTH-1]);
         neg_rem     <= div_signed & div_src1[DIV_WIDTH-1];
         if (zero_div) begin
            div_quotient  <= DIV_ZERO_QUOT;
            div_remainder <= div_src1;
         end
      end else if ((state == RUN) && !div_cancel) begin
         cnt         <= cnt + DIV_CNT_W'(1);
         part_rem    <= step_rem;
         dividend_sh <= {dividend_sh[DIV_WIDTH-2:0], 1'b0};
         quot_acc    <= quot_final[DIV_WIDTH-2:0];
         if (cnt == CNT_LAST) begin
            div_quotient  <= neg_quot ? -quot_final : quot_final;
            div_remainder <= neg_rem  ? -step_rem   : step_rem;
         end
      end else if (div_cancel) begin
         cnt <= '0;
      end
   end

`ifdef DIV_ZERO_FLAG_EN
   logic zero_flag;

   // Divide-by-zero indication, held until the next accepted start or a cancel.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         zero_flag <= 1'b0;
      end else if (div_cancel) begin
         zero_flag <= 1'b0;
      end else if (accept) begin
         zero_flag <= zero_div;
      end
   end

   assign div_by_zero = zero_flag;
`endif

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed table-driven bench for div_unit
module tb_div_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        div_start;
   logic        div_signed;
   logic [31:0] div_src1;
   logic [31:0] div_src2;
   logic        div_cancel;
   logic        div_busy;
   logic        div_ready;
   logic [31:0] div_quotient;
   logic [31:0] div_remainder;
`ifdef DIV_ZERO_FLAG_EN
   logic        div_by_zero;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   div_unit dut (
      .clk           (clk),
      .resetn        (resetn),
      .div_start     (div_start),
      .div_signed    (div_signed),
      .div_src1      (div_src1),
      .div_src2      (div_src2),
      .div_cancel    (div_cancel),
      .div_busy      (div_busy),
      .div_ready     (div_ready),
`ifdef DIV_ZERO_FLAG_EN
      .div_by_zero   (div_by_zero),
`endif
      .div_quotient  (div_quotient),
      .div_remainder (div_remainder)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Present a start during the current cycle T.
   task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk);
      #1;
      div_start  = 1'b1;
      div_cancel = 1'b0;
      div_signed = sgn;
      div_src1   = a;
      div_src2   = b;
   endtask

   // Advance into the next cycle, drive its controls, and stop at its negedge.
   task automatic step_cycle(input logic start, input logic cancel);
      @(posedge clk);
      #1;
      div_start  = start;
      div_cancel = cancel;
      @(negedge clk);
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      int   ready_at;
      int   ready_cnt;
      int   busy_bad;
      v         = vecs[idx];
      ready_at  = -1;
      ready_cnt = 0;
      busy_bad  = 0;
      launch(v.sgn, v.a, v.b);
      for (int k = 1; k <= v.lat + 1; k++) begin
         step_cycle(1'b0, 1'b0);
         if (div_ready) begin
            ready_cnt++;
            if (ready_at < 0) ready_at = k;
         end
         if (k <= v.lat && !div_busy) busy_bad++;
         if (k == v.lat) begin
            check($sformatf("v%0d_quotient", idx), div_quotient, v.q);
            check($sformatf("v%0d_remainder", idx), div_remainder, v.r);
`ifdef DIV_ZERO_FLAG_EN
            check($sformatf("v%0d_by_zero", idx), {31'b0, div_by_zero}, {31'b0, (v.b == 32'd0)});
`endif
         end
         if (k == v.lat + 1) begin
            check($sformatf("v%0d_busy_after", idx), {31'b0, div_busy}, 32'd0);
         end
      end
      check($sformatf("v%0d_ready_cycle", idx), ready_at, v.lat);
      check($sformatf("v%0d_ready_count", idx), ready_cnt, 32'd1);
      check($sformatf("v%0d_busy_gaps", idx), busy_bad, 32'd0);
   endtask

   initial begin
      int bad;

      vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
      vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
      vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
      vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1};
      vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
      vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
      vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          33};
      vecs[7]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          33};
      vecs[8]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1};
      vecs[9]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33};
      vecs[10] = '{1'b0, 32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          33};
      vecs[11] = '{1'b0, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,          33};

      resetn     = 1'b0;
      div_start  = 1'b0;
      div_signed = 1'b0;
      div_cancel = 1'b0;
      div_src1   = '0;
      div_src2   = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'b0, div_busy}, 32'd0);
      check("rst_ready", {31'b0, div_ready}, 32'd0);
      check("rst_quotient", div_quotient, 32'd0);
      check("rst_remainder", div_remainder, 32'd0);
`ifdef DIV_ZERO_FLAG_EN
      check("rst_by_zero", {31'b0, div_by_zero}, 32'd0);
`endif
      @(posedge clk);
      #1;
      resetn = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_vec(i);
      end

      // Cancel at T+10, restart at T+11, expect completion at T+44.
      bad = 0;
      launch(1'b0, 32'd100, 32'd7);
      for (int k = 1; k <= 45; k++) begin
         step_cycle(k == 11, k == 10);
         if (k == 2) begin
            div_src1 = 32'd1000;
            div_src2 = 32'd10;
         end
         if (k < 44 && div_ready) bad++;
         if (k == 11) begin
            check("cancel_idle", {31'b0, div_busy}, 32'd0);
            check("cancel_q_held", div_quotient, vecs[11].q);
            check("cancel_r_held", div_remainder, vecs[11].r);
         end
         if (k == 44) begin
            check("restart_ready", {31'b0, div_ready}, 32'd1);
            check("restart_quotient", div_quotient, 32'd100);
            check("restart_remainder", div_remainder, 32'd0);
         end
         if (k == 45) check("restart_idle", {31'b0, div_busy}, 32'd0);
      end
      check("cancel_no_ready", bad, 32'd0);

      // Cancel beats a simultaneous start while in DONE.
      bad = 0;
      launch(1'b0, 32'd9, 32'd0);
      step_cycle(1'b1, 1'b1);
      check("prio_ready", {31'b0, div_ready}, 32'd1);
      check("prio_quotient", div_quotient, 32'hFFFF_FFFF);
      check("prio_remainder", div_remainder, 32'd9);
`ifdef DIV_ZERO_FLAG_EN
      check("prio_by_zero_set", {31'b0, div_by_zero}, 32'd1);
`endif
      for (int k = 2; k <= 5; k++) begin
         step_cycle(1'b0, 1'b0);
         if (div_ready || div_busy) bad++;
`ifdef DIV_ZERO_FLAG_EN
         if (k == 2) check("prio_by_zero_clr", {31'b0, div_by_zero}, 32'd0);
`endif
      end
      check("prio_stays_idle", bad, 32'd0);

      // Back-to-back: second start accepted in DONE at T+33.
      bad = 0;
      launch(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
      for (int k = 1; k <= 67; k++) begin
         step_cycle(k == 33, 1'b0);
         if (k == 2) begin
            div_signed = 1'b0;
            div_src1   = 32'hDEAD_BEEF;
            div_src2   = 32'h10;
         end
         if (div_ready && k != 33 && k != 66) bad++;
         if (k == 33) begin
            check("b2b_first_ready", {31'b0, div_ready}, 32'd1);
            check("b2b_first_q", div_quotient, 32'd14);
            check("b2b_first_r", div_remainder, 32'hFFFF_FFFE);
         end
         if (k == 34) check("b2b_busy_run", {31'b0, div_busy}, 32'd1);
         if (k == 66) begin
            check("b2b_second_ready", {31'b0, div_ready}, 32'd1);
            check("b2b_second_q", div_quotient, 32'h0DEA_DBEE);
            check("b2b_second_r", div_remainder, 32'hF);
         end
         if (k == 67) check("b2b_idle", {31'b0, div_busy}, 32'd0);
      end
      check("b2b_extra_ready", bad, 32'd0);

      // Reset pulse mid-RUN at T+20.
      bad = 0;
      launch(1'b0, 32'd100, 32'd7);
      for (int k = 1; k < 20; k++) step_cycle(1'b0, 1'b0);
      @(posedge clk);
      #1;
      resetn = 1'b0;
      #2;
      check("midrst_busy", {31'b0, div_busy}, 32'd0);
      check("midrst_ready", {31'b0, div_ready}, 32'd0);
      check("midrst_quotient", div_quotient, 32'd0);
      check("midrst_remainder", div_remainder, 32'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step_cycle(1'b0, 1'b0);
         if (div_ready || div_busy) bad++;
      end
      check("midrst_no_ready", bad, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
